// File: rtl/apb_master_bridge_if.sv
// Request/response and APB bus bundle for apb_master_bridge.
// The master modport is the bridge side; slave is the system/peripheral side.
interface apb_master_bridge_if #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int NUM_SLV = 4,
  parameter int SEL_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
);
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_write;
  logic [SEL_W-1:0]            req_sel;
  logic [ADDR_W-1:0]           req_addr;
  logic [DATA_W-1:0]           req_wdata;
  logic                        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        rsp_err;
  logic [NUM_SLV-1:0]          psel;
  logic                        penable;
  logic                        pwrite;
  logic [ADDR_W-1:0]           paddr;
  logic [DATA_W-1:0]           pwdata;
  logic [NUM_SLV*DATA_W-1:0]   prdata;
  logic [NUM_SLV-1:0]          pready;
  logic [NUM_SLV-1:0]          pslverr;

  modport master (
    input  req_valid, req_write, req_sel, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_sel, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding request bridge onto an APB bus with NUM_SLV slaves.
// Handles wait states, slave errors, wait timeout and out-of-range selects.
module apb_master_bridge #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int NUM_SLV  = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  apb_master_bridge_if.master bus
);
  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [SEL_W:0] SEL_LIM  = (SEL_W+1)'(NUM_SLV);
  localparam logic [7:0]     WAIT_LIM = 8'(WAIT_MAX);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          wait_reg, wait_next;
  logic [NUM_SLV-1:0]  psel_reg, psel_next;
  logic                penable_reg, penable_next;
  logic                pwrite_reg, pwrite_next;
  logic [ADDR_W-1:0]   paddr_reg, paddr_next;
  logic [DATA_W-1:0]   pwdata_reg, pwdata_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic                rsp_err_reg, rsp_err_next;
  logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;

  logic                sel_ok;
  logic [NUM_SLV-1:0]  sel_onehot;
  logic                ready_sel;
  logic                err_sel;
  logic [DATA_W-1:0]   rdata_sel;
  logic [DATA_W-1:0]   rdata_slv [NUM_SLV];
  logic [7:0]          wait_inc;

  assign sel_ok = ({1'b0, bus.req_sel} < SEL_LIM);

  // The registered one-hot psel masks every per-slave input, so non-selected
  // slaves cannot influence completion, error or read data.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
      assign sel_onehot[gi] = (bus.req_sel == SEL_W'(gi));
      assign rdata_slv[gi]  = psel_reg[gi] ? bus.prdata[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  assign ready_sel = |(bus.pready & psel_reg);
  assign err_sel   = |(bus.pslverr & psel_reg);
  assign wait_inc  = wait_reg + 8'd1;

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      rdata_sel = rdata_sel | rdata_slv[i];
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_next      = wait_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;
    unique case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (sel_ok) begin
            state_next  = SETUP;
            wait_next   = 8'd0;
            psel_next   = sel_onehot;
            pwrite_next = bus.req_write;
            paddr_next  = bus.req_addr;
            pwdata_next = bus.req_wdata;
          end else begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end
      ACCESS: begin
        if (ready_sel) begin
          state_next     = IDLE;
          psel_next      = '0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = err_sel;
          rsp_rdata_next = (!pwrite_reg && !err_sel) ? rdata_sel : '0;
        end else begin
          wait_next = wait_inc;
          if (wait_inc == WAIT_LIM) begin
            state_next     = IDLE;
            psel_next      = '0;
            penable_next   = 1'b0;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      wait_reg      <= 8'd0;
      psel_reg      <= '0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wait_reg      <= wait_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  // Ready is gated by reset so it is low during reset and high in the first released cycle.
  assign bus.req_ready = (state_reg == IDLE) && reset;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.psel      = psel_reg;
  assign bus.penable   = penable_reg;
  assign bus.pwrite    = pwrite_reg;
  assign bus.paddr     = paddr_reg;
  assign bus.pwdata    = pwdata_reg;
endmodule
